// File: rtl/seven_seg_digit_driver.sv
// Display back end for the stopwatch scan FSM: anode dead time, a per-frame digit
// snapshot, leading-zero blanking, colon blinking and output polarity.
module seven_seg_digit_driver #(
  parameter int BLANK_CYCLES   = 4,
  parameter int BLINK_FRAMES   = 250,
  parameter int ACTIVE_LOW_AN  = 1,
  parameter int ACTIVE_LOW_SEG = 1
) (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic [2:0]  state_i,
  input  logic [15:0] digits_i,
  input  logic        lz_blank_i,
  input  logic [1:0]  colon_mode_i,
  output logic [4:0]  anode_o,
  output logic [6:0]  seg_o
);

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b011,
    S3 = 3'b100,
    S4 = 3'b010
  } scan_state_t;

  localparam int BW = $clog2(BLANK_CYCLES + 2);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [4:0]    AN_INV     = (ACTIVE_LOW_AN != 0) ? 5'h1F : 5'h00;
  localparam logic [6:0]    SEG_INV    = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;

  logic [2:0]    state_q;
  logic [BW-1:0] blank_cnt;
  logic [BW-1:0] cnt_next;
  logic [15:0]   snapshot;
  logic [15:0]   snap_next;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic          state_change;
  logic          frame_start;
  logic          colon_vis;
  logic          blank1, blank2, blank3;
  logic [4:0]    an_sel;
  logic [6:0]    seg_next;
  logic [3:0]    nib;
  logic          show_digit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  assign state_change = (state_i != state_q);
  assign frame_start  = (state_i == S0) && (state_q != S0);
  // Dig0 at the frame-start edge must already come from the fresh digits.
  assign snap_next    = frame_start ? digits_i : snapshot;
  assign cnt_next     = state_change ? BLANK_INIT :
                        ((blank_cnt == '0) ? '0 : blank_cnt - 1'b1);

  assign colon_vis = (colon_mode_i == 2'b01) || (colon_mode_i == 2'b11) ||
                     ((colon_mode_i == 2'b10) && blink_phase);

  assign blank3 = lz_blank_i && (snap_next[15:12] == 4'd0);
  assign blank2 = blank3 && (snap_next[11:8] == 4'd0);
  assign blank1 = blank2 && (snap_next[7:4] == 4'd0);

  always_comb begin
    an_sel     = 5'b00000;
    nib        = 4'd0;
    show_digit = 1'b0;
    seg_next   = 7'h00;
    case (state_i)
      S0: begin an_sel = 5'b00001; nib = snap_next[3:0];   show_digit = 1'b1;    end
      S1: begin an_sel = 5'b00010; nib = snap_next[7:4];   show_digit = !blank1; end
      S2: begin an_sel = 5'b00100; nib = snap_next[11:8];  show_digit = !blank2; end
      S3: begin an_sel = 5'b01000; nib = snap_next[15:12]; show_digit = !blank3; end
      S4: begin an_sel = 5'b10000; seg_next = colon_vis ? 7'h03 : 7'h00;       end
      default: ;
    endcase
    if (show_digit) seg_next = decode(nib);
  end

  // Outputs are computed from the next state so segments change at the switch edge
  // while the anode waits for the dead-time counter to drain.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S0;
      blank_cnt   <= BLANK_INIT;
      snapshot    <= 16'h0000;
      blink_phase <= 1'b1;
      frame_cnt   <= '0;
      anode_o     <= AN_INV;
      seg_o       <= SEG_INV;
    end else begin
      state_q   <= state_i;
      blank_cnt <= cnt_next;
      if (frame_start) begin
        snapshot <= digits_i;
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
      anode_o <= ((cnt_next == '0) ? an_sel : 5'b00000) ^ AN_INV;
      seg_o   <= seg_next ^ SEG_INV;
    end
  end

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Scoreboard bench for seven_seg_digit_driver: a driver pushes reference-model
// predictions into a queue and a monitor compares them one cycle later.
module tb_seven_seg_digit_driver;

  localparam int BLANK = 4;
  localparam int BF    = 2;
  localparam logic [2:0] S0 = 3'b000, S1 = 3'b001, S2 = 3'b011, S3 = 3'b100, S4 = 3'b010;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  state_in = S0;
  logic [15:0] digits_in = 16'h0000;
  logic        lz_in = 1'b0;
  logic [1:0]  cm_in = 2'b00;
  logic [4:0]  anode;
  logic [6:0]  seg;

  logic [15:0] cur_digits = 16'h0000;
  logic        cur_lz = 1'b0;
  logic [1:0]  cur_cm = 2'b00;

  int errors = 0;
  int checks = 0;

  typedef struct packed { logic [4:0] an; logic [6:0] sg; } exp_t;
  exp_t sb[$];

  int          m_state;
  int          m_since;
  logic [15:0] m_snap;
  int          m_frames;
  bit          m_phase;

  string glyph[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                       "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  seven_seg_digit_driver #(
    .BLANK_CYCLES(BLANK), .BLINK_FRAMES(BF), .ACTIVE_LOW_AN(1), .ACTIVE_LOW_SEG(1)
  ) dut (
    .clk_i(clk), .reset_n(reset_n), .state_i(state_in), .digits_i(digits_in),
    .lz_blank_i(lz_in), .colon_mode_i(cm_in), .anode_o(anode), .seg_o(seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] segs(input string s);
    logic [6:0] r = 7'h00;
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
    return r;
  endfunction

  function automatic int position(input int s);
    case (s)
      0: return 0;
      1: return 1;
      3: return 2;
      4: return 3;
      2: return 4;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_since = 0; m_snap = 16'h0000; m_frames = 0; m_phase = 1'b1;
  endtask

  task automatic model_step(input int st);
    int idx, rest, nibv;
    logic [4:0] lit;
    logic [6:0] sg;
    if (st != m_state) begin
      if (st == 0) begin
        m_snap = cur_digits;
        m_frames++;
        if (m_frames == BF) begin m_frames = 0; m_phase = !m_phase; end
      end
      m_state = st;
      m_since = 0;
    end else if (m_since < 1000) begin
      m_since++;
    end
    idx = position(st);
    lit = 5'b0;
    sg  = 7'h00;
    if (idx >= 0 && m_since >= BLANK) lit[idx] = 1'b1;
    if (idx >= 0 && idx < 4) begin
      rest = int'(m_snap) >> (4 * idx);
      nibv = rest & 15;
      if (!(cur_lz && idx > 0 && rest == 0))
        sg = (nibv > 9) ? segs("g") : segs(glyph[nibv]);
    end else if (idx == 4) begin
      if (cur_cm == 2'd1 || cur_cm == 2'd3 || (cur_cm == 2'd2 && m_phase)) sg = segs("ab");
    end
    sb.push_back('{an: ~lit, sg: ~sg});
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic applyStimulus(input logic [2:0] st);
    state_in  = st;
    digits_in = cur_digits;
    lz_in     = cur_lz;
    cm_in     = cur_cm;
    model_step(int'(st));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hold(input logic [2:0] st, input int n);
    repeat (n) applyStimulus(st);
  endtask

  task automatic frame(input int dwell);
    hold(S0, dwell); hold(S1, dwell); hold(S2, dwell); hold(S3, dwell); hold(S4, dwell);
  endtask

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset_n && sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("anode", {7'h0, anode}, {7'h0, e.an});
      checkOutput("seg", {5'h0, seg}, {5'h0, e.sg});
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1 checkOutput("reset_anode", {7'h0, anode}, 12'h01F);
    checkOutput("reset_seg", {5'h0, seg}, 12'h07F);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Post-reset dead time while parked on S0.
    hold(S0, 8);

    // Plain rotation, colon on.
    cur_digits = 16'h1234; cur_lz = 1'b0; cur_cm = 2'b01;
    repeat (2) frame(20);

    // Leading-zero blanking cases.
    cur_lz = 1'b1;
    cur_digits = 16'h0005; repeat (2) frame(8);
    cur_digits = 16'h0000; frame(8);
    cur_digits = 16'h0A05; frame(8);
    cur_digits = 16'h1000; frame(6);

    // Digits change mid-frame must not affect the frame in progress.
    cur_lz = 1'b0; cur_digits = 16'h1234; frame(6);
    hold(S0, 6); hold(S1, 6); hold(S2, 3);
    cur_digits = 16'h5678;
    hold(S2, 3); hold(S3, 6); hold(S4, 6);
    frame(6);

    // Colon blinking then colon off.
    cur_cm = 2'b10; repeat (8) frame(5);
    cur_cm = 2'b00; repeat (2) frame(5);

    // Illegal state then recovery, plus short dwell inside dead time.
    cur_cm = 2'b11;
    hold(3'b111, 10); hold(S1, 8);
    hold(S2, 2); hold(S3, 1); hold(3'b101, 2); hold(S3, 7);

    // Asynchronous reset mid-S3.
    #2 reset_n = 1'b0;
    #1 checkOutput("async_anode", {7'h0, anode}, 12'h01F);
    checkOutput("async_seg", {5'h0, seg}, 12'h07F);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    hold(S3, 6);

    // Randomized states, dwell, digits and modes.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) cur_digits = 16'($urandom);
      cur_lz = 1'($urandom_range(0, 1));
      cur_cm = 2'($urandom_range(0, 3));
      hold(3'($urandom_range(0, 7)), $urandom_range(1, 8));
    end
    for (int i = 0; i < 20; i++) begin
      cur_digits = 16'($urandom_range(0, 16'h0FFF));
      frame($urandom_range(1, 6));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
